rob_retire: RTL and testbench

- Reorder buffer plus in-order retire stage, sitting directly downstream of rename.
- Accepts one renamed instruction per cycle from rename and tracks its completion.
- Retires completed instructions in program order, at most one per cycle.
- On retire, returns the displaced physical register (old_rd) to rename's free list via push_free_reg/freed_reg.

---
 rtl/rob_retire_if.sv | 41 ++++
 rtl/rob_retire.sv | 113 +++++++++++
 tb/tb_rob_retire.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_if.sv
// Rename/complete/retire signal bundle for rob_retire.
// The master side is rename plus execution; the slave side is the ROB itself.
interface rob_retire_if #(
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int TAG_WIDTH  = 4
);
  // Allocation is a valid/ready handshake: an entry is taken at a rising edge
  // exactly when alloc_valid && alloc_ready; payload must be stable while valid.
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [AREG_WIDTH-1:0] alloc_arch_rd;
  logic [PREG_WIDTH-1:0] alloc_rrd;
  logic [PREG_WIDTH-1:0] alloc_old_rd;
  logic                  alloc_has_rd;
  logic [11:0]           alloc_pc;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  cmpl_valid;
  logic [TAG_WIDTH-1:0]  cmpl_tag;
  logic                  commit_valid;
  logic [AREG_WIDTH-1:0] commit_arch_rd;
  logic [PREG_WIDTH-1:0] commit_rrd;
  logic [11:0]           commit_pc;
  logic                  push_free_reg;
  logic [PREG_WIDTH-1:0] freed_reg;
  logic [TAG_WIDTH:0]    rob_count;

  modport master (
    output alloc_valid, alloc_arch_rd, alloc_rrd, alloc_old_rd, alloc_has_rd,
           alloc_pc, cmpl_valid, cmpl_tag,
    input  alloc_ready, alloc_tag, commit_valid, commit_arch_rd, commit_rrd,
           commit_pc, push_free_reg, freed_reg, rob_count
  );

  modport slave (
    input  alloc_valid, alloc_arch_rd, alloc_rrd, alloc_old_rd, alloc_has_rd,
           alloc_pc, cmpl_valid, cmpl_tag,
    output alloc_ready, alloc_tag, commit_valid, commit_arch_rd, commit_rrd,
           commit_pc, push_free_reg, freed_reg, rob_count
  );
endinterface

// File: rtl/rob_retire.sv
// Reorder buffer with in-order single-wide retire; returns old_rd to the free list.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer in one cycle.
module rob_retire #(
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int DEPTH      = 16,
  parameter int TAG_WIDTH  = 4
) (
  input logic clk,
  input logic rst,
`ifdef ROB_FLUSH_EN
  input logic flush,
`endif
  rob_retire_if.slave rob
);

  localparam logic [TAG_WIDTH:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [DEPTH-1:0]      has_rd_q;
  logic [AREG_WIDTH-1:0] arch_rd_q [DEPTH];
  logic [PREG_WIDTH-1:0] rrd_q     [DEPTH];
  logic [PREG_WIDTH-1:0] old_rd_q  [DEPTH];
  logic [11:0]           pc_q      [DEPTH];
  logic [TAG_WIDTH:0]    head_q, head_d;
  logic [TAG_WIDTH:0]    tail_q, tail_d;

  logic                 flush_w;
  logic [TAG_WIDTH-1:0] head_idx;
  logic [TAG_WIDTH-1:0] tail_idx;
  logic                 full;
  logic                 alloc_fire;
  logic                 cmpl_hit;
  logic                 commit_fire;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  // Full is taken from registered pointers only, so a retire never frees a slot same-cycle.
  assign full        = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  assign alloc_fire  = rob.alloc_valid && !full && !flush_w;
  assign cmpl_hit    = rob.cmpl_valid && valid_q[rob.cmpl_tag] && !flush_w;
  assign commit_fire = valid_q[head_idx] && done_q[head_idx] && !flush_w;

  assign rob.alloc_ready    = !full && !flush_w;
  assign rob.alloc_tag      = flush_w ? '0 : tail_idx;
  assign rob.rob_count      = flush_w ? '0 : (tail_q - head_q);
  assign rob.commit_valid   = commit_fire;
  assign rob.commit_arch_rd = commit_fire ? arch_rd_q[head_idx] : '0;
  assign rob.commit_rrd     = commit_fire ? rrd_q[head_idx]     : '0;
  assign rob.commit_pc      = commit_fire ? pc_q[head_idx]      : '0;
  assign rob.push_free_reg  = commit_fire && has_rd_q[head_idx];
  assign rob.freed_reg      = commit_fire ? old_rd_q[head_idx]  : '0;

  // Retire is applied last so it wins over a redundant completion of the head.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_w) begin
      valid_d = '0;
      done_d  = '0;
      tail_d  = head_q;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + PTR_ONE;
      end
      if (cmpl_hit) begin
        done_d[rob.cmpl_tag] = 1'b1;
      end
      if (commit_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire && !rst) begin
      has_rd_q[tail_idx]  <= rob.alloc_has_rd && (rob.alloc_arch_rd != '0);
      arch_rd_q[tail_idx] <= rob.alloc_arch_rd;
      rrd_q[tail_idx]     <= rob.alloc_rrd;
      old_rd_q[tail_idx]  <= rob.alloc_old_rd;
      pc_q[tail_idx]      <= rob.alloc_pc;
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: expected retire records are queued at allocation
// and a negedge monitor pops and compares each one the DUT commits.
module tb_rob_retire;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  rob_retire_if rif ();

  rob_retire dut (
    .clk (clk),
    .rst (rst),
`ifdef ROB_FLUSH_EN
    .flush (flush),
`endif
    .rob (rif)
  );

  // record = {arch_rd, rrd, pc, push_free_reg, freed_reg}
  logic [29:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.alloc_valid   = 1'b0;
    rif.alloc_arch_rd = '0;
    rif.alloc_rrd     = '0;
    rif.alloc_old_rd  = '0;
    rif.alloc_has_rd  = 1'b0;
    rif.alloc_pc      = '0;
    rif.cmpl_valid    = 1'b0;
    rif.cmpl_tag      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive one allocation; when expect_it is set, queue the record it will retire with.
  task automatic drive_alloc(input logic [4:0] arch, input logic [5:0] rrd, input logic [5:0] old,
                             input logic has, input logic [11:0] pc, input logic expect_it);
    logic push;
    rif.alloc_valid   = 1'b1;
    rif.alloc_arch_rd = arch;
    rif.alloc_rrd     = rrd;
    rif.alloc_old_rd  = old;
    rif.alloc_has_rd  = has;
    rif.alloc_pc      = pc;
    push = has && (arch != 5'd0);
    if (expect_it) exp_q.push_back({arch, rrd, pc, push, old});
  endtask

  task automatic drive_cmpl(input logic [3:0] tag);
    rif.cmpl_valid = 1'b1;
    rif.cmpl_tag   = tag;
  endtask

  always @(negedge clk) begin
    logic [29:0] rec;
    logic [29:0] e;
    if (!rst && rif.commit_valid) begin
      rec = {rif.commit_arch_rd, rif.commit_rrd, rif.commit_pc, rif.push_free_reg, rif.freed_reg};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_commit: got record 0x%0h with no retire expected", rec);
      end else begin
        e = exp_q.pop_front();
        check("commit_rec", {2'b0, rec}, {2'b0, e});
      end
    end
  end

  initial begin
    idle_inputs();
    do_reset();

    // reset state
    check("rst_count", 32'(rif.rob_count), 0);
    check("rst_ready", 32'(rif.alloc_ready), 1);
    check("rst_tag", 32'(rif.alloc_tag), 0);
    check("rst_commit", 32'(rif.commit_valid), 0);
    check("rst_push", 32'(rif.push_free_reg), 0);

    // single alloc/complete/retire
    drive_alloc(5'd5, 6'd33, 6'd5, 1'b1, 12'h004, 1'b1);
    tick();
    rif.alloc_valid = 1'b0;
    drive_cmpl(4'd0);
    check("t1_count1", 32'(rif.rob_count), 1);
    check("t1_no_early_commit", 32'(rif.commit_valid), 0);
    tick();
    rif.cmpl_valid = 1'b0;
    check("t1_commit", 32'(rif.commit_valid), 1);
    check("t1_push", 32'(rif.push_free_reg), 1);
    check("t1_freed", 32'(rif.freed_reg), 5);
    tick();
    check("t1_count0", 32'(rif.rob_count), 0);
    check("t1_commit_off", 32'(rif.commit_valid), 0);
    check("t1_rrd_zero", 32'(rif.commit_rrd), 0);

    // out-of-order completion 2,0,1 retires in order 0,1,2
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'(i + 1), 6'(i + 40), 6'(i + 10), 1'b1, 12'(12'h010 + i), 1'b1);
      check("t2_alloc_tag", 32'(rif.alloc_tag), 32'(i));
      tick();
    end
    rif.alloc_valid = 1'b0;
    drive_cmpl(4'd2);
    tick();
    check("t2_wait_head", 32'(rif.commit_valid), 0);
    drive_cmpl(4'd0);
    tick();
    check("t2_ret0", 32'(rif.commit_valid), 1);
    drive_cmpl(4'd1);
    tick();
    check("t2_ret1", 32'(rif.commit_valid), 1);
    rif.cmpl_valid = 1'b0;
    tick();
    check("t2_ret2", 32'(rif.commit_valid), 1);
    tick();
    check("t2_done_commit", 32'(rif.commit_valid), 0);
    check("t2_done_count", 32'(rif.rob_count), 0);

    // fill, refuse 17th, retire while full, then wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(5'(i + 1), 6'(i + 16), 6'(i), 1'b1, 12'(12'h100 + i), 1'b1);
      tick();
    end
    drive_alloc(5'd20, 6'd50, 6'd7, 1'b1, 12'h200, 1'b0);
    check("t3_full_ready", 32'(rif.alloc_ready), 0);
    check("t3_full_count", 32'(rif.rob_count), 16);
    tick();
    check("t3_refused_count", 32'(rif.rob_count), 16);
    check("t3_refused_tag", 32'(rif.alloc_tag), 0);
    drive_cmpl(4'd0);
    tick();
    rif.cmpl_valid = 1'b0;
    check("t3_ready_while_retire", 32'(rif.alloc_ready), 0);
    check("t3_commit_while_full", 32'(rif.commit_valid), 1);
    tick();
    check("t3_after_retire_count", 32'(rif.rob_count), 15);
    check("t3_after_retire_ready", 32'(rif.alloc_ready), 1);
    check("t3_wrap_tag", 32'(rif.alloc_tag), 0);
    exp_q.push_back({5'd20, 6'd50, 12'h200, 1'b1, 6'd7});
    tick();
    rif.alloc_valid = 1'b0;
    check("t3_accept_count", 32'(rif.rob_count), 16);
    check("t3_accept_tag", 32'(rif.alloc_tag), 1);
    for (int t = 1; t < 16; t++) begin
      drive_cmpl(4'(t));
      tick();
    end
    drive_cmpl(4'd0);
    tick();
    rif.cmpl_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t3_drained", 32'(rif.rob_count), 0);

    // x0 destination never frees
    do_reset();
    drive_alloc(5'd0, 6'd9, 6'd3, 1'b1, 12'h300, 1'b1);
    tick();
    rif.alloc_valid = 1'b0;
    drive_cmpl(4'd0);
    tick();
    rif.cmpl_valid = 1'b0;
    check("t4_commit", 32'(rif.commit_valid), 1);
    check("t4_no_push", 32'(rif.push_free_reg), 0);
    tick();

    // reset with live entries, then a stale completion
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(5'(i + 3), 6'(i + 20), 6'(i + 2), 1'b1, 12'(12'h400 + i), 1'b1);
      tick();
    end
    rif.alloc_valid = 1'b0;
    drive_cmpl(4'd1);
    tick();
    drive_cmpl(4'd3);
    tick();
    check("t5_held_count", 32'(rif.rob_count), 5);
    check("t5_head_not_done", 32'(rif.commit_valid), 0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("t5_rst_count", 32'(rif.rob_count), 0);
    check("t5_rst_tag", 32'(rif.alloc_tag), 0);
    tick();
    rif.cmpl_valid = 1'b0;
    check("t5_stale_commit", 32'(rif.commit_valid), 0);
    check("t5_stale_count", 32'(rif.rob_count), 0);

`ifdef ROB_FLUSH_EN
    // flush with a same-cycle completion
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_alloc(5'(i + 1), 6'(i + 30), 6'(i + 1), 1'b1, 12'(12'h500 + i), 1'b1);
      tick();
    end
    rif.alloc_valid = 1'b0;
    drive_cmpl(4'd0);
    tick();
    drive_cmpl(4'd1);
    tick();
    rif.cmpl_valid = 1'b0;
    tick();
    check("t6_pre_count", 32'(rif.rob_count), 0);
    for (int i = 0; i < 6; i++) begin
      drive_alloc(5'(i + 4), 6'(i + 40), 6'(i + 8), 1'b1, 12'(12'h600 + i), 1'b1);
      check("t6_alloc_tag", 32'(rif.alloc_tag), 32'(i + 2));
      tick();
    end
    rif.alloc_valid = 1'b0;
    flush = 1'b1;
    drive_cmpl(4'd2);
    #1;
    check("t6_flush_commit", 32'(rif.commit_valid), 0);
    check("t6_flush_count", 32'(rif.rob_count), 0);
    exp_q.delete();
    tick();
    flush = 1'b0;
    rif.cmpl_valid = 1'b0;
    check("t6_post_count", 32'(rif.rob_count), 0);
    check("t6_post_tag", 32'(rif.alloc_tag), 2);
    check("t6_post_ready", 32'(rif.alloc_ready), 1);
    tick();
    check("t6_no_retire", 32'(rif.commit_valid), 0);
`endif

    tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
